// File: rtl/katsayi_blok_tamponu_pkg.sv
// Shared widths, read-side state encoding and types for the
// coefficient block assembler and its storage banks.
package katsayi_blok_tamponu_pkg;

    localparam int HDATA_BIT      = 16;
    localparam int BLOCK_BIT      = 3;
    localparam int BLOCK_AREA     = 64;
    localparam int BLOCK_AREA_BIT = 6;

    typedef enum logic {
        BOS  = 1'b0,
        AKIS = 1'b1
    } oku_durum_t;

    typedef logic [HDATA_BIT-1:0]      katsayi_t;
    typedef logic [BLOCK_AREA_BIT-1:0] konum_t;
    typedef logic [BLOCK_BIT-1:0]      eksen_t;

    // Row-major linear address of an 8x8 position.
    function automatic konum_t konum(input eksen_t row, input eksen_t col);
        return {row, col};
    endfunction

endpackage

// File: rtl/katsayi_banki.sv
// One 8x8 coefficient bank: 64-entry store plus written-mask.
// Ports: clk_i/rst_i, write (yaz, yaz_adr, yaz_veri), mask clear
// (temizle), masked combinational read (oku_adr -> oku_veri).
module katsayi_banki
    import katsayi_blok_tamponu_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     yaz,
    input  konum_t   yaz_adr,
    input  katsayi_t yaz_veri,
    input  logic     temizle,
    input  konum_t   oku_adr,
    output katsayi_t oku_veri
);

    katsayi_t              mem [BLOCK_AREA];
    logic [BLOCK_AREA-1:0] maske_r;

    // Data needs no reset: the mask decides what is visible.
    always_ff @(posedge clk_i) begin
        if (yaz)
            mem[yaz_adr] <= yaz_veri;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            maske_r <= '0;
        end else begin
            if (temizle)
                maske_r <= '0;
            if (yaz)
                maske_r[yaz_adr] <= 1'b1;
        end
    end

    // Unwritten positions read as zero.
    assign oku_veri = maske_r[oku_adr] ? mem[oku_adr] : '0;

endmodule

// File: rtl/katsayi_blok_tamponu.sv
// Double-buffered 8x8 block assembler: sparse (value,row,col) in,
// dense row-major 64-beat blocks out; ct_* write side, iy_* stream.
module katsayi_blok_tamponu
    import katsayi_blok_tamponu_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [HDATA_BIT-1:0] ct_veri_i,
    input  logic [BLOCK_BIT-1:0] ct_row_i,
    input  logic [BLOCK_BIT-1:0] ct_col_i,
    input  logic                 ct_gecerli_i,
    output logic                 ct_hazir_o,
    input  logic                 blok_son_i,
    output logic [HDATA_BIT-1:0] iy_veri_o,
    output logic [BLOCK_BIT-1:0] iy_row_o,
    output logic [BLOCK_BIT-1:0] iy_col_o,
    output logic                 iy_son_o,
    output logic                 iy_gecerli_o,
    input  logic                 iy_hazir_i
);

    logic       yaz_bank_r;
    logic       oku_bank_r;
    logic [1:0] dolu_r;
    logic [1:0] dolu_n;
    logic       son_bekleyen_r;
    konum_t     oku_idx_r;
    oku_durum_t durum_r;

    logic       kabul;
    logic       yaz_dolu;
    logic       son_etkin;
    logic       son_ertele;
    logic       bekleyen_kapat;
    logic       kapat;
    logic       el_sikis;
    logic       blok_bitti;
    logic       diger_bank;
    logic       yukle;
    logic       sec_bank;
    konum_t     oku_adr;
    konum_t     yaz_adr;
    katsayi_t   veri0;
    katsayi_t   veri1;
    katsayi_t   okunan;

    assign yaz_dolu   = dolu_r[yaz_bank_r];
    assign ct_hazir_o = !yaz_dolu && !son_bekleyen_r;
    assign kabul      = ct_gecerli_i && ct_hazir_o;
    assign yaz_adr    = konum(ct_row_i, ct_col_i);

    // A strobe while a close is already pending is dropped.
    assign son_etkin      = blok_son_i && !son_bekleyen_r && !yaz_dolu;
    assign son_ertele     = blok_son_i && !son_bekleyen_r && yaz_dolu;
    assign bekleyen_kapat = son_bekleyen_r && !yaz_dolu;
    assign kapat          = son_etkin || bekleyen_kapat;

    assign diger_bank = ~oku_bank_r;
    assign el_sikis   = iy_gecerli_o && iy_hazir_i;
    assign blok_bitti = (durum_r == AKIS) && el_sikis
                        && (oku_idx_r == 6'd63);

    // Load the output register on start, on each mid-block
    // handshake, and on a back-to-back bank switch.
    assign yukle = ((durum_r == BOS) && dolu_r[oku_bank_r])
                || ((durum_r == AKIS) && el_sikis && !blok_bitti)
                || (blok_bitti && dolu_r[diger_bank]);

    always_comb begin
        oku_adr  = oku_idx_r + 6'd1;
        sec_bank = oku_bank_r;
        if (durum_r == BOS) begin
            oku_adr = '0;
        end else if (blok_bitti) begin
            oku_adr  = '0;
            sec_bank = diger_bank;
        end
    end

    assign okunan = sec_bank ? veri1 : veri0;

    // Close and free never hit the same bank in one cycle.
    always_comb begin
        dolu_n = dolu_r;
        if (blok_bitti)
            dolu_n[oku_bank_r] = 1'b0;
        if (kapat)
            dolu_n[yaz_bank_r] = 1'b1;
    end

    katsayi_banki u_bank0 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .yaz      (kabul && !yaz_bank_r),
        .yaz_adr  (yaz_adr),
        .yaz_veri (ct_veri_i),
        .temizle  (blok_bitti && !oku_bank_r),
        .oku_adr  (oku_adr),
        .oku_veri (veri0)
    );

    katsayi_banki u_bank1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .yaz      (kabul && yaz_bank_r),
        .yaz_adr  (yaz_adr),
        .yaz_veri (ct_veri_i),
        .temizle  (blok_bitti && oku_bank_r),
        .oku_adr  (oku_adr),
        .oku_veri (veri1)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            yaz_bank_r     <= 1'b0;
            oku_bank_r     <= 1'b0;
            dolu_r         <= '0;
            son_bekleyen_r <= 1'b0;
            oku_idx_r      <= '0;
            durum_r        <= BOS;
            iy_veri_o      <= '0;
            iy_row_o       <= '0;
            iy_col_o       <= '0;
            iy_son_o       <= 1'b0;
            iy_gecerli_o   <= 1'b0;
        end else begin
            dolu_r <= dolu_n;
            if (kapat)
                yaz_bank_r <= ~yaz_bank_r;
            if (son_ertele)
                son_bekleyen_r <= 1'b1;
            else if (bekleyen_kapat)
                son_bekleyen_r <= 1'b0;
            if (blok_bitti)
                oku_bank_r <= diger_bank;

            if (yukle) begin
                durum_r      <= AKIS;
                oku_idx_r    <= oku_adr;
                iy_veri_o    <= okunan;
                iy_row_o     <= oku_adr[5:3];
                iy_col_o     <= oku_adr[2:0];
                iy_son_o     <= (oku_adr == 6'd63);
                iy_gecerli_o <= 1'b1;
            end else if (blok_bitti) begin
                durum_r      <= BOS;
                oku_idx_r    <= '0;
                iy_veri_o    <= '0;
                iy_row_o     <= '0;
                iy_col_o     <= '0;
                iy_son_o     <= 1'b0;
                iy_gecerli_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_katsayi_blok_tamponu.sv
// Directed bench for katsayi_blok_tamponu: fills blocks, drains
// them and compares every beat against a local 64-entry model.
module tb_katsayi_blok_tamponu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] ct_veri_i;
    logic [2:0]  ct_row_i;
    logic [2:0]  ct_col_i;
    logic        ct_gecerli_i;
    logic        ct_hazir_o;
    logic        blok_son_i;
    logic [15:0] iy_veri_o;
    logic [2:0]  iy_row_o;
    logic [2:0]  iy_col_o;
    logic        iy_son_o;
    logic        iy_gecerli_o;
    logic        iy_hazir_i;

    int passed = 0;
    int total  = 0;
    logic [15:0] e [64];

    always #5 clk_i = ~clk_i;

    katsayi_blok_tamponu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ct_veri_i    (ct_veri_i),
        .ct_row_i     (ct_row_i),
        .ct_col_i     (ct_col_i),
        .ct_gecerli_i (ct_gecerli_i),
        .ct_hazir_o   (ct_hazir_o),
        .blok_son_i   (blok_son_i),
        .iy_veri_o    (iy_veri_o),
        .iy_row_o     (iy_row_o),
        .iy_col_o     (iy_col_o),
        .iy_son_o     (iy_son_o),
        .iy_gecerli_o (iy_gecerli_o),
        .iy_hazir_i   (iy_hazir_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr_e();
        for (int i = 0; i < 64; i++)
            e[i] = '0;
    endtask

    task automatic put(input int r, input int c, input logic [15:0] v);
        int n = 0;
        ct_veri_i    = v;
        ct_row_i     = 3'(r);
        ct_col_i     = 3'(c);
        ct_gecerli_i = 1'b1;
        while (!ct_hazir_o && n < 300) begin
            step();
            n++;
        end
        if (n >= 300)
            chk("put_timeout", 32'(n), 32'(0));
        step();
        ct_gecerli_i = 1'b0;
    endtask

    task automatic son();
        blok_son_i = 1'b1;
        step();
        blok_son_i = 1'b0;
    endtask

    task automatic collect(input bit bp, input bit contig, input string tag);
        int idx = 0;
        int cyc = 0;
        logic [22:0] beat;
        logic [22:0] exp;
        logic [5:0]  p;
        if (contig)
            chk({tag, "_contig"}, 32'(iy_gecerli_o), 32'(1));
        while (idx < 64 && cyc < 3000) begin
            iy_hazir_i = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (iy_gecerli_o) begin
                p    = 6'(idx);
                beat = {iy_son_o, iy_row_o, iy_col_o, iy_veri_o};
                exp  = {(idx == 63), p[5:3], p[2:0], e[idx]};
                chk(tag, 32'(beat), 32'(exp));
                if (iy_hazir_i)
                    idx++;
            end
            step();
            cyc++;
        end
        chk({tag, "_count"}, 32'(idx), 32'(64));
    endtask

    initial begin
        int n;
        rst_i        = 1'b1;
        ct_veri_i    = '0;
        ct_row_i     = '0;
        ct_col_i     = '0;
        ct_gecerli_i = 1'b0;
        blok_son_i   = 1'b0;
        iy_hazir_i   = 1'b0;
        step();
        step();
        step();
        chk("rst_hazir", 32'(ct_hazir_o), 32'(1));
        chk("rst_gecerli", 32'(iy_gecerli_o), 32'(0));
        chk("rst_out", 32'({iy_son_o, iy_row_o, iy_col_o, iy_veri_o}), 32'(0));
        rst_i = 1'b0;
        step();

        // Basic block with latency check.
        iy_hazir_i = 1'b1;
        clr_e();
        e[0]  = 16'd5;
        e[1]  = 16'hFFFD;
        e[17] = 16'd7;
        put(0, 0, 16'd5);
        put(0, 1, 16'hFFFD);
        put(2, 1, 16'd7);
        son();
        chk("lat_t1", 32'(iy_gecerli_o), 32'(0));
        step();
        chk("lat_t2", 32'(iy_gecerli_o), 32'(1));
        collect(1'b0, 1'b0, "blk1");
        chk("blk1_idle", 32'(iy_gecerli_o), 32'(0));

        // Empty block, then a block proving the mask was cleared.
        clr_e();
        son();
        collect(1'b0, 1'b0, "empty");
        e[63] = 16'd9;
        put(7, 7, 16'd9);
        son();
        collect(1'b0, 1'b0, "last9");

        // Both banks full, third close pends.
        iy_hazir_i = 1'b0;
        put(0, 0, 16'd1);
        son();
        put(1, 1, 16'd2);
        son();
        step();
        step();
        chk("full_hazir", 32'(ct_hazir_o), 32'(0));
        son();
        step();
        chk("pend_hazir", 32'(ct_hazir_o), 32'(0));
        chk("held_a0", 32'({iy_gecerli_o, iy_veri_o}), 32'({1'b1, 16'd1}));
        clr_e();
        e[0] = 16'd1;
        collect(1'b0, 1'b0, "blkA");
        clr_e();
        e[9] = 16'd2;
        collect(1'b0, 1'b1, "blkB");
        clr_e();
        collect(1'b0, 1'b1, "blkC");
        chk("c_idle", 32'(iy_gecerli_o), 32'(0));
        chk("c_hazir", 32'(ct_hazir_o), 32'(1));

        // Random backpressure.
        clr_e();
        e[37] = 16'h1234;
        e[50] = 16'h00AA;
        put(4, 5, 16'h1234);
        put(6, 2, 16'h00AA);
        son();
        collect(1'b1, 1'b0, "bp");

        // Overwrite and same-cycle close.
        iy_hazir_i = 1'b1;
        clr_e();
        e[27] = 16'd6;
        e[45] = 16'h0055;
        put(3, 3, 16'd4);
        put(3, 3, 16'd6);
        chk("same_hazir", 32'(ct_hazir_o), 32'(1));
        ct_veri_i    = 16'h0055;
        ct_row_i     = 3'd5;
        ct_col_i     = 3'd5;
        ct_gecerli_i = 1'b1;
        blok_son_i   = 1'b1;
        step();
        ct_gecerli_i = 1'b0;
        blok_son_i   = 1'b0;
        collect(1'b0, 1'b0, "same");

        // Reset mid-stream at idx 30.
        put(0, 0, 16'h0077);
        son();
        n = 0;
        while (!(iy_gecerli_o && iy_row_o == 3'd3 && iy_col_o == 3'd6)
               && n < 200) begin
            step();
            n++;
        end
        chk("idx30_seen", 32'(n < 200), 32'(1));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mrst_out",
            32'({iy_gecerli_o, iy_son_o, iy_row_o, iy_col_o, iy_veri_o}),
            32'(0));
        chk("mrst_hazir", 32'(ct_hazir_o), 32'(1));
        step();
        step();
        chk("mrst_quiet", 32'(iy_gecerli_o), 32'(0));
        clr_e();
        e[8] = 16'h0011;
        put(1, 0, 16'h0011);
        son();
        collect(1'b0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
